// File: rtl/latch_bank_wr_ctrl_pkg.sv
// Shared types for the latch-bank write sequencer: FSM state encoding,
// hold-counter width and the two-way round-robin pick function.
package latch_bank_wr_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_OPEN  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Wide enough for HOLD_CYC up to 15.
   localparam int HCNT_W = 4;

   // When both request, grant the one that was not granted last.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
      logic [1:0] g;
      g = req;
      if (req == 2'b11) g = last ? 2'b01 : 2'b10;
      return g;
   endfunction

endpackage

// File: rtl/latch_bank_wr_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the last-granted flop moves on every accepted grant.
module rr_arb2
   import latch_bank_wr_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);

   logic last_q, last_d;

   always_comb begin
      grant_o = rr_pick(req_i, last_q);
      last_d  = last_q;
      if (advance_i && (grant_o != 2'b00)) last_d = grant_o[1];
   end

   // Reset to "requester 1 was last" so requester 0 wins the first tie.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) last_q <= 1'b1;
      else       last_q <= last_d;
   end

endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer for a bank of active-low-gate latch words: arbitrates two
// requesters and drives registered, single-cycle gate pulses around stable data.
module latch_bank_wr_ctrl
   import latch_bank_wr_ctrl_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int AW       = 3,
   parameter int DW       = 16,
   parameter int HOLD_CYC = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             REQ0,
   input  logic [AW-1:0]    ADDR0,
   input  logic [DW-1:0]    WDATA0,
   output logic             ACK0,
   input  logic             REQ1,
   input  logic [AW-1:0]    ADDR1,
   input  logic [DW-1:0]    WDATA1,
   output logic             ACK1,
   output logic [DW-1:0]    LAT_D,
   output logic [DEPTH-1:0] LAT_GN,
   output logic             BUSY,
   output logic             ERR
);

   state_e             state_q, state_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic               gid_q, gid_d;
   logic [HCNT_W-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]      latd_q, latd_d;
   logic [DEPTH-1:0]   gn_q, gn_d;
   logic               ack0_q, ack0_d;
   logic               ack1_q, ack1_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   logic [1:0]         arb_req, grant;
   logic               take, in_rng, hold_end;

   // The just-acked requester is masked in DONE so a still-high REQ is not re-served.
   always_comb begin
      arb_req = 2'b00;
      case (state_q)
         ST_IDLE: arb_req = {REQ1, REQ0};
         ST_DONE: arb_req = {REQ1 & ~gid_q, REQ0 & gid_q};
         default: arb_req = 2'b00;
      endcase
   end

   rr_arb2 u_arb (
      .clk_i     (CLK),
      .rst_i     (RESET),
      .req_i     (arb_req),
      .advance_i (take),
      .grant_o   (grant)
   );

   assign take     = (grant != 2'b00);
   assign in_rng   = (int'(addr_q) < DEPTH);
   assign hold_end = (state_q == ST_HOLD) && (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      gid_d   = gid_q;
      cnt_d   = cnt_q;
      latd_d  = latd_q;
      gn_d    = '1;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE:  if (take) state_d = ST_SETUP;
         ST_SETUP: state_d = ST_OPEN;
         ST_OPEN:  state_d = ST_HOLD;
         ST_HOLD:  if (hold_end) state_d = ST_DONE;
         ST_DONE:  state_d = take ? ST_SETUP : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Capture on the SETUP-entry edge; LAT_D is only ever loaded here.
      if (take) begin
         gid_d  = grant[1];
         addr_d = grant[1] ? ADDR1  : ADDR0;
         latd_d = grant[1] ? WDATA1 : WDATA0;
      end

      // Gate is registered: decoded during SETUP, visible for the OPEN cycle only.
      if (state_q == ST_SETUP) begin
         for (int i = 0; i < DEPTH; i++)
            if (int'(addr_q) == i) gn_d[i] = 1'b0;
      end

      if (state_q == ST_OPEN)      cnt_d = HCNT_W'(HOLD_CYC - 1);
      else if (state_q == ST_HOLD) cnt_d = cnt_q - HCNT_W'(1);

      if (hold_end) begin
         ack0_d = ~gid_q;
         ack1_d = gid_q;
         err_d  = ~in_rng;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         gid_q   <= 1'b0;
         cnt_q   <= '0;
         latd_q  <= '0;
         gn_q    <= '1;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
         latd_q  <= latd_d;
         gn_q    <= gn_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign LAT_D  = latd_q;
   assign LAT_GN = gn_q;
   assign ACK0   = ack0_q;
   assign ACK1   = ack1_q;
   assign BUSY   = busy_q;
   assign ERR    = err_q;

endmodule
